// File: rtl/disc_dac_pkg.sv
// Shared types and constants for the discriminator-threshold DAC loader.
// Holds the FSM state encoding, DAC command nibbles and the DISC_VAL reset code.
package disc_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_HOLD = 3'd3,
    ST_GAP  = 3'd4
  } dac_state_e;

  localparam logic [3:0] DAC_CMD_NOP    = 4'h0;
  localparam logic [3:0] DAC_CMD_WR_UPD = 4'h3;

  localparam logic [7:0] DISC_RESET_VAL = 8'h30;

endpackage

// File: rtl/disc_dac_loader_if.sv
// Request side and SPI side of the threshold DAC loader.
// The master is the command decoder / bench; the slave is the loader.
interface disc_dac_loader_if;

  logic       set_dac;
  logic [7:0] disc_val;
  logic       dac_sclk;
  logic       dac_din;
  logic       dac_cs_n;
  logic       busy;
  logic       done;

  modport master (
    output set_dac,
    output disc_val,
    input  dac_sclk,
    input  dac_din,
    input  dac_cs_n,
    input  busy,
    input  done
  );

  modport slave (
    input  set_dac,
    input  disc_val,
    output dac_sclk,
    output dac_din,
    output dac_cs_n,
    output busy,
    output done
  );

endinterface

// File: rtl/spi_half_timer.sv
// Loadable down-counter; 'expire' is high during the last of load_val cycles.
// Reloading on the expire cycle gives back-to-back periods with no idle gap.
module spi_half_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = (cnt == 8'd1);

endmodule

// File: rtl/disc_dac_loader.sv
// Serial loader for the discriminator-threshold DAC: one MSB-first SPI
// frame per SET_DAC edge, depth-1 request queue, one boot load after reset.
module disc_dac_loader
  import disc_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned FRAME_BITS    = 16,
  parameter logic [3:0]  CMD_PREFIX    = DAC_CMD_WR_UPD,
  parameter int unsigned PAD_BITS      = 4,
  parameter int unsigned CS_GAP        = 8,
  parameter int unsigned LOAD_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  disc_dac_loader_if.slave   bus
);

  localparam logic [7:0] DIV_CNT = 8'(CLK_DIV);
  localparam logic [7:0] GAP_CNT = 8'(CS_GAP);
  localparam logic [4:0] LAST    = 5'(FRAME_BITS - 1);
  localparam bit         BOOT    = (LOAD_ON_RESET != 0);

  dac_state_e            state;
  logic                  set_d;
  logic                  boot_done;
  logic                  pending;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            bitcnt;
  logic                  sclk;
  logic                  din;
  logic                  cs_n;
  logic                  busy;
  logic                  done;

  logic                  req;
  logic                  start;
  logic                  expire;
  logic                  tmr_load;
  logic [7:0]            tmr_val;
  logic [FRAME_BITS-1:0] frame;

  assign req      = bus.set_dac & ~set_d;
  assign start    = (state == ST_IDLE) & (req | pending);
  assign tmr_load = start | ((state != ST_IDLE) & expire);
  assign tmr_val  = (state == ST_HOLD) ? GAP_CNT : DIV_CNT;
  assign frame    = {CMD_PREFIX, bus.disc_val, {PAD_BITS{1'b0}}};

  spi_half_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      set_d     <= 1'b0;
      boot_done <= 1'b0;
      pending   <= 1'b0;
      shreg     <= '0;
      bitcnt    <= 5'd0;
      sclk      <= 1'b0;
      din       <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      set_d     <= bus.set_dac;
      done      <= 1'b0;
      boot_done <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (req | pending) begin
            state   <= ST_LOW;
            shreg   <= frame;
            din     <= frame[FRAME_BITS-1];
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            bitcnt  <= 5'd0;
            pending <= 1'b0;
          end
        end
        ST_LOW: begin
          if (req) pending <= 1'b1;
          if (expire) begin
            state <= ST_HIGH;
            sclk  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (req) pending <= 1'b1;
          if (expire) begin
            sclk <= 1'b0;
            if (bitcnt == LAST) begin
              state <= ST_HOLD;
            end else begin
              state  <= ST_LOW;
              bitcnt <= bitcnt + 5'd1;
              shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
              din    <= shreg[FRAME_BITS-2];
            end
          end
        end
        ST_HOLD: begin
          if (req) pending <= 1'b1;
          if (expire) begin
            state <= ST_GAP;
            cs_n  <= 1'b1;
            din   <= 1'b0;
          end
        end
        ST_GAP: begin
          if (expire) begin
            done    <= 1'b1;
            pending <= 1'b0;
            // a request landing on the exit cycle still gets its frame
            if (pending | req) begin
              state  <= ST_LOW;
              shreg  <= frame;
              din    <= frame[FRAME_BITS-1];
              cs_n   <= 1'b0;
              bitcnt <= 5'd0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (req) begin
            pending <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (BOOT && !boot_done) pending <= 1'b1;
    end
  end

  assign bus.dac_sclk = sclk;
  assign bus.dac_din  = din;
  assign bus.dac_cs_n = cs_n;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_disc_dac_loader.sv
// Directed bench for disc_dac_loader: boot load, single/held/queued requests,
// reset mid-frame, with a passive SPI monitor checking protocol on every run.
module tb_disc_dac_loader;
  import disc_dac_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  disc_dac_loader_if bus();

  disc_dac_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #25 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // monitor state, owned by the monitor process only
  logic [15:0] frames[$];
  int          bitsq[$];
  int          lows[$];
  logic [15:0] shf = '0;
  int          mon_bits = 0;
  int          low_len = 0;
  int          hi_run = 0;
  int          gap_last = 0;
  int          hr = 0;
  int          hi_min = 255;
  int          hi_max = 0;
  int          ndone = 0;
  int          viol = 0;
  logic        have_prev = 1'b0;
  logic        sclk_q = 1'b0;
  logic        din_q = 1'b0;
  logic        cs_q = 1'b1;
  logic        done_q = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev <= 1'b0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      cs_q      <= 1'b1;
      done_q    <= 1'b0;
      hi_run    <= 0;
      hr        <= 0;
    end else begin
      viol <= viol
        + int'(bus.dac_cs_n && cs_q && (bus.dac_sclk != sclk_q))
        + int'(sclk_q && bus.dac_sclk && (bus.dac_din != din_q))
        + int'(bus.done && done_q)
        + int'(!bus.dac_cs_n && cs_q && have_prev && (hi_run < 8));
      if (!bus.dac_cs_n) begin
        if (cs_q) begin
          if (have_prev) gap_last <= hi_run;
          shf      <= '0;
          mon_bits <= 0;
          low_len  <= 1;
        end else begin
          low_len <= low_len + 1;
          if (bus.dac_sclk && !sclk_q) begin
            shf      <= {shf[14:0], bus.dac_din};
            mon_bits <= mon_bits + 1;
          end
        end
      end else begin
        if (!cs_q) begin
          frames.push_back(shf);
          bitsq.push_back(mon_bits);
          lows.push_back(low_len);
          have_prev <= 1'b1;
          hi_run    <= 1;
        end else begin
          hi_run <= hi_run + 1;
        end
      end
      if (bus.dac_sclk) begin
        hr <= hr + 1;
      end else if (sclk_q) begin
        hi_min <= (hr < hi_min) ? hr : hi_min;
        hi_max <= (hr > hi_max) ? hr : hi_max;
        hr     <= 0;
      end
      if (bus.done) ndone <= ndone + 1;
      sclk_q <= bus.dac_sclk;
      din_q  <= bus.dac_din;
      cs_q   <= bus.dac_cs_n;
      done_q <= bus.done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fr(input int i);
    return (i < frames.size()) ? 32'(frames[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] bq(input int i);
    return (i < bitsq.size()) ? 32'(bitsq[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] lq(input int i);
    return (i < lows.size()) ? 32'(lows[i]) : 32'hDEAD;
  endfunction

  task automatic wait_bits(input int n, input string tag);
    for (int i = 0; i < 1000 && mon_bits != n; i++) @(posedge clk);
    if (mon_bits != n) chk(tag, mon_bits, n);
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk);
    bus.disc_val = v;
    bus.set_dac  = 1'b1;
    @(negedge clk);
    bus.set_dac  = 1'b0;
  endtask

  int nf;
  int nd;
  int cyc;
  logic cs_first;

  initial begin
    rst_n        = 1'b0;
    bus.set_dac  = 1'b0;
    bus.disc_val = DISC_RESET_VAL;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus.dac_cs_n, 1);
    chk("rst_sclk", bus.dac_sclk, 0);
    chk("rst_din",  bus.dac_din, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    // boot load without any request
    nf = frames.size();
    nd = ndone;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("boot_nframes", frames.size() - nf, 1);
    chk("boot_frame", fr(nf), 32'h3300);
    chk("boot_bits", bq(nf), 16);
    chk("boot_cs_low", lq(nf), 132);
    chk("boot_ndone", ndone - nd, 1);
    chk("boot_idle", bus.busy, 0);

    // single pulse: latency and frame shape
    nf = frames.size();
    nd = ndone;
    @(negedge clk);
    bus.disc_val = 8'hA5;
    bus.set_dac  = 1'b1;
    cyc = 0;
    cs_first = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        cs_first    = bus.dac_cs_n;
        bus.set_dac = 1'b0;
      end
    end while (!bus.done && cyc < 400);
    chk("a5_cs_fall", cs_first, 0);
    chk("a5_done_lat", cyc, 141);
    repeat (20) @(negedge clk);
    chk("a5_nframes", frames.size() - nf, 1);
    chk("a5_frame", fr(nf), 32'h3A50);
    chk("a5_cs_low", lq(nf), 132);
    chk("a5_ndone", ndone - nd, 1);

    // level held 50 cycles is one request
    nf = frames.size();
    @(negedge clk);
    bus.disc_val = 8'h01;
    bus.set_dac  = 1'b1;
    repeat (50) @(negedge clk);
    bus.set_dac  = 1'b0;
    repeat (300) @(negedge clk);
    chk("held_nframes", frames.size() - nf, 1);
    chk("held_frame", fr(nf), 32'h3010);
    chk("held_idle", bus.busy, 0);

    // queued requests merge, latest value wins, in-flight frame intact
    nf = frames.size();
    nd = ndone;
    pulse(8'h5C);
    wait_bits(5, "q_wait5");
    pulse(8'h10);
    wait_bits(9, "q_wait9");
    pulse(8'h22);
    repeat (400) @(negedge clk);
    chk("q_nframes", frames.size() - nf, 2);
    chk("q_frame0", fr(nf), 32'h35C0);
    chk("q_frame1", fr(nf + 1), 32'h3220);
    chk("q_gap", gap_last, 8);
    chk("q_ndone", ndone - nd, 2);
    chk("q_idle", bus.busy, 0);

    // asynchronous reset mid-frame, then a clean boot frame
    pulse(8'hA5);
    wait_bits(7, "r_wait7");
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_cs_n", bus.dac_cs_n, 1);
    chk("r_sclk", bus.dac_sclk, 0);
    chk("r_busy", bus.busy, 0);
    bus.disc_val = DISC_RESET_VAL;
    repeat (3) @(negedge clk);
    nf = frames.size();
    nd = ndone;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("r_nframes", frames.size() - nf, 1);
    chk("r_frame", fr(nf), 32'h3300);
    chk("r_bits", bq(nf), 16);
    chk("r_ndone", ndone - nd, 1);

    chk("proto_viol", viol, 0);
    chk("sclk_hi_min", hi_min, 4);
    chk("sclk_hi_max", hi_max, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
